fifo_drain_packer: RTL and testbench
====================================

// Module: fifo_drain_packer
// PURPOSE
//  Read-side consumer for the 2-bit show-ahead FIFO: pops entries when FIFO is non-empty and packs
//  WORDS consecutive entries into one wide word, presented on a valid/ready output stream.
//  Sits between the FIFO read port (dout/empty/pop) and a wide downstream sink; io_flush emits a
//  partial word early.
// PARAMETERS
//  DATA_WIDTH  2   width of one FIFO entry (matches FIFO io_dout)
//  WORDS       4   entries packed per output word; >=2. Output width OUT_W = DATA_WIDTH*WORDS
//  (derived)   CNT_W = $clog2(WORDS+1), width of beat counter / io_out_count
// PORTS
//  clk            in   1          rising-edge clock
//  reset          in   1          synchronous, active-high reset
//  io_fifo_dout   in   DATA_WIDTH FIFO head entry; valid whenever io_fifo_empty==0 (fall-through)
//  io_fifo_empty  in   1          FIFO empty flag
//  io_fifo_pop    out  1          pop strobe to FIFO; one entry consumed per cycle it is high
//  io_flush       in   1          close current partial word and present it
//  io_out_data    out  OUT_W      packed word; entry k at bits [k*DATA_WIDTH +: DATA_WIDTH]
//  io_out_count   out  CNT_W      number of valid entries in io_out_data (1..WORDS)
//  io_out_valid   out  1          output word valid
//  io_out_ready   in   1          downstream accepts word when valid&ready
// BEHAVIOUR
//  State: FILL, HOLD. Registers: state, cnt (CNT_W), data (OUT_W), count (CNT_W).
//  Reset (sync, high): state=FILL, cnt=0, data=0, count=0; io_out_valid=0; io_fifo_pop=0 while reset=1.
//  Reset mid-HOLD or mid-FILL discards partial/held word; no entries popped during reset.
//  io_fifo_pop = (state==FILL) & ~io_fifo_empty & ~reset; combinational, never depends on io_fifo_dout.
//  FILL, pop=1: data[cnt*DATA_WIDTH +: DATA_WIDTH] <= io_fifo_dout; cnt <= cnt+1.
//   - if cnt==WORDS-1 at pop: count<=WORDS, state<=HOLD (word valid next cycle).
//   - else if io_flush same cycle: count<=cnt+1, state<=HOLD (popped entry included).
//  FILL, pop=0: if io_flush & cnt>0 -> count<=cnt, state<=HOLD; if cnt==0 flush is ignored.
//  io_flush outside FILL is ignored (not queued).
//  HOLD: io_out_valid=1, io_out_data/io_out_count stable, io_fifo_pop=0.
//   - valid & ready: state<=FILL, cnt<=0, data<=0 (unused slots of next word read as 0).
//   - valid & ~ready: hold indefinitely, no FIFO traffic.
//  io_out_valid = (state==HOLD); io_out_data = data; io_out_count = count (0 outside HOLD).
//  Latency: word valid the cycle after its last pop. Throughput: WORDS+1 cycles per full word
//  (one FILL-entry cycle after each handshake; no bypass).
//  Entries in a partial (flushed) word above io_out_count are 0.
//  Never pops more than WORDS entries per word; never pops when io_fifo_empty=1 (no underflow).
// TESTING
//  1 FIFO preloaded 1,2,3,0; ready=1 -> pop high 4 cycles, then valid=1 one cycle,
//    io_out_data=8'h39, count=4, then FILL with cnt=0.
//  2 Full word held with ready=0 for 5 cycles -> data/count stable, pop=0, FIFO occupancy unchanged;
//    ready=1 -> single handshake, valid drops next cycle.
//  3 Pop 3 then 1, FIFO empties, pulse flush -> valid next cycle, io_out_data=8'h07, count=2.
//  4 FIFO empty, cnt=0, flush pulsed -> pop stays 0, valid stays 0 (flush ignored).
//  5 Flush coincident with 3rd pop (entries 2,2,1) -> io_out_data=8'h1A, count=3; 4th FIFO entry
//    remains in FIFO and becomes entry 0 of next word.
//  6 Reset asserted during HOLD -> valid=0, count=0 next cycle, no pop during reset;
//    subsequent 4 entries 3,3,3,3 produce io_out_data=8'hFF, count=4.

Source files
------------

// File: rtl/fifo_drain_packer.sv
// Read-side packer for a show-ahead FIFO: pops entries while filling and presents
// WORDS consecutive entries (or a flushed partial word) on a valid/ready stream.
module fifo_drain_packer #(
    parameter int unsigned DATA_WIDTH = 2,
    parameter int unsigned WORDS      = 4
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [DATA_WIDTH-1:0]             io_fifo_dout,
    input  logic                              io_fifo_empty,
    output logic                              io_fifo_pop,
    input  logic                              io_flush,
    output logic [DATA_WIDTH*WORDS-1:0]       io_out_data,
    output logic [$clog2(WORDS+1)-1:0]        io_out_count,
    output logic                              io_out_valid,
    input  logic                              io_out_ready
);

    localparam int unsigned OUT_W = DATA_WIDTH * WORDS;
    localparam int unsigned CNT_W = $clog2(WORDS + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WORDS - 1);

    typedef enum logic {FILL, HOLD} state_t;

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   cnt, cnt_nxt;
    logic [CNT_W-1:0]   count, count_nxt;
    logic [OUT_W-1:0]   data, data_nxt;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= FILL;
            cnt   <= '0;
            count <= '0;
            data  <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            count <= count_nxt;
            data  <= data_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        count_nxt   = count;
        data_nxt    = data;
        io_fifo_pop = (state == FILL) && !io_fifo_empty && !reset;

        case (state)
            FILL: begin
                if (io_fifo_pop) begin
                    for (int unsigned k = 0; k < WORDS; k++) begin
                        if (cnt == CNT_W'(k)) begin
                            data_nxt[k*DATA_WIDTH +: DATA_WIDTH] = io_fifo_dout;
                        end
                    end
                    cnt_nxt = cnt + CNT_W'(1);
                    // A flush on the popping cycle still includes the popped entry.
                    if (cnt == LAST) begin
                        count_nxt = CNT_W'(WORDS);
                        state_nxt = HOLD;
                    end else if (io_flush) begin
                        count_nxt = cnt + CNT_W'(1);
                        state_nxt = HOLD;
                    end
                end else if (io_flush && (cnt != '0)) begin
                    count_nxt = cnt;
                    state_nxt = HOLD;
                end
            end
            HOLD: begin
                if (io_out_ready) begin
                    state_nxt = FILL;
                    cnt_nxt   = '0;
                    data_nxt  = '0;
                end
            end
            default: state_nxt = FILL;
        endcase
    end

    assign io_out_valid = (state == HOLD);
    assign io_out_data  = data;
    assign io_out_count = (state == HOLD) ? count : '0;

endmodule

// File: tb/tb_fifo_drain_packer.sv
// Bench for fifo_drain_packer: directed scenarios then random traffic, all checked
// against a queue-based model of the FIFO and the word under construction.
module tb_fifo_drain_packer;

    localparam int unsigned DW = 2;
    localparam int unsigned WORDS = 4;

    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic [DW-1:0]  io_fifo_dout = '0;
    logic           io_fifo_empty = 1'b1;
    logic           io_fifo_pop;
    logic           io_flush = 1'b0;
    logic [DW*WORDS-1:0] io_out_data;
    logic [2:0]     io_out_count;
    logic           io_out_valid;
    logic           io_out_ready = 1'b0;

    int n_checks = 0;
    int n_errors = 0;

    // Reference: FIFO contents, entries gathered for the current word, and whether it is presented.
    logic [DW-1:0] fifo[$];
    logic [DW-1:0] cur[$];
    bit            held = 0;
    bit            exp_pop = 0;

    fifo_drain_packer #(.DATA_WIDTH(DW), .WORDS(WORDS)) dut (
        .clk(clk), .reset(reset),
        .io_fifo_dout(io_fifo_dout), .io_fifo_empty(io_fifo_empty), .io_fifo_pop(io_fifo_pop),
        .io_flush(io_flush),
        .io_out_data(io_out_data), .io_out_count(io_out_count),
        .io_out_valid(io_out_valid), .io_out_ready(io_out_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] pack_cur();
        logic [31:0] r = '0;
        for (int k = 0; k < cur.size(); k++) r |= 32'(cur[k]) << (DW * k);
        return r;
    endfunction

    // Drive inputs just after a rising edge, then compare on the falling edge.
    task automatic settle(input bit rst, input bit fl, input bit rdy);
        reset         = rst;
        io_flush      = fl;
        io_out_ready  = rdy;
        io_fifo_empty = (fifo.size() == 0);
        io_fifo_dout  = (fifo.size() == 0) ? '0 : fifo[0];
        @(negedge clk);
        exp_pop = !held && (fifo.size() > 0) && !rst;
        check("pop",   io_fifo_pop,  exp_pop);
        check("valid", io_out_valid, held);
        check("data",  io_out_data,  pack_cur());
        check("count", io_out_count, held ? cur.size() : 0);
    endtask

    task automatic advance();
        @(posedge clk);
        if (reset) begin
            cur.delete();
            held = 0;
        end else if (held) begin
            if (io_out_ready) begin
                cur.delete();
                held = 0;
            end
        end else begin
            if (exp_pop) cur.push_back(fifo.pop_front());
            if (cur.size() == WORDS || (io_flush && cur.size() > 0)) held = 1;
        end
        #1;
    endtask

    task automatic cyc(input bit rst, input bit fl, input bit rdy);
        settle(rst, fl, rdy);
        advance();
    endtask

    logic [DW*WORDS-1:0] saved;
    int                  occ;

    initial begin
        repeat (2) @(posedge clk);
        #1;
        // Reset state
        settle(1, 0, 0);
        check("rst_valid", io_out_valid, 0);
        check("rst_count", io_out_count, 0);
        advance();

        // 1: four pops then a full word 8'h39
        fifo = '{2'd1, 2'd2, 2'd3, 2'd0};
        for (int i = 0; i < 4; i++) begin
            settle(0, 0, 1);
            check("t1_pop", io_fifo_pop, 1);
            advance();
        end
        settle(0, 0, 1);
        check("t1_data", io_out_data, 8'h39);
        check("t1_count", io_out_count, 4);
        advance();
        settle(0, 0, 1);
        check("t1_valid_drop", io_out_valid, 0);
        advance();

        // 2: full word held under back-pressure, FIFO untouched
        fifo = '{2'd2, 2'd1, 2'd0, 2'd3, 2'd1};
        repeat (4) cyc(0, 0, 0);
        saved = io_out_data;
        occ = fifo.size();
        for (int i = 0; i < 5; i++) begin
            settle(0, 0, 0);
            check("t2_stable", io_out_data, saved);
            check("t2_pop0", io_fifo_pop, 0);
            advance();
        end
        check("t2_occ", fifo.size(), occ);
        cyc(0, 0, 1);
        settle(0, 0, 0);
        check("t2_valid_drop", io_out_valid, 0);
        advance();
        cyc(0, 0, 1);   // pop leftover entry as entry 0
        cyc(0, 1, 1);   // flush it out
        cyc(0, 0, 1);   // handshake

        // 3: two pops, FIFO empty, flush -> 8'h07 count 2
        fifo = '{2'd3, 2'd1};
        repeat (2) cyc(0, 0, 1);
        cyc(0, 1, 1);
        settle(0, 0, 1);
        check("t3_data", io_out_data, 8'h07);
        check("t3_count", io_out_count, 2);
        advance();

        // 4: flush with nothing gathered is ignored
        cyc(0, 1, 1);
        settle(0, 0, 1);
        check("t4_valid", io_out_valid, 0);
        check("t4_pop", io_fifo_pop, 0);
        advance();

        // 5: flush on the 3rd pop; 4th entry starts the next word
        fifo = '{2'd2, 2'd2, 2'd1, 2'd3};
        cyc(0, 0, 1);
        cyc(0, 0, 1);
        cyc(0, 1, 1);
        settle(0, 0, 1);
        check("t5_data", io_out_data, 8'h1A);
        check("t5_count", io_out_count, 3);
        check("t5_left", fifo.size(), 1);
        advance();
        settle(0, 0, 1);
        check("t5_next_dout", io_fifo_pop, 1);
        advance();
        settle(0, 0, 1);
        check("t5_next_entry", io_out_data, 8'h03);
        advance();
        cyc(0, 1, 1);
        cyc(0, 0, 1);

        // 6: reset during HOLD and during FILL, then 8'hFF
        fifo = '{2'd0, 2'd1, 2'd2, 2'd3};
        repeat (4) cyc(0, 0, 0);
        cyc(1, 0, 0);
        fifo.push_back(2'd3);
        settle(1, 0, 0);
        check("t6_pop_in_rst", io_fifo_pop, 0);
        check("t6_valid", io_out_valid, 0);
        check("t6_count", io_out_count, 0);
        advance();
        repeat (3) fifo.push_back(2'd3);
        repeat (4) cyc(0, 0, 0);
        settle(0, 0, 1);
        check("t6_data", io_out_data, 8'hFF);
        check("t6_cnt", io_out_count, 4);
        advance();

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            cyc(($urandom_range(0, 99) == 0), ($urandom_range(0, 7) == 0),
                ($urandom_range(0, 3) != 0));
            if ($urandom_range(0, 1) == 1 && fifo.size() < 6)
                fifo.push_back(DW'($urandom_range(0, 3)));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
